dmem_arbiter: RTL

- Two-port arbiter and store sequencer in front of the single-port data memory.
- The memory has a combinational read and a word-wide synchronous write.
- Port 0 serves the CPU load/store unit; port 1 serves the program/debug loader.
- The block arbitrates round-robin, returns registered read responses, and turns byte/halfword stores into a read-modify-write of the enclosing word.

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and store sequencer for a single-port data memory.
// The memory reads combinationally and writes whole words on the clock edge.
// Byte and halfword stores therefore take two cycles: the enclosing word is read
// and merged in IDLE, then written back in RMW_WR.
module dmem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    req_valid,
    output logic [1:0]                    req_ready,
    input  logic [1:0]                    req_we,
    input  logic [1:0][1:0]               req_size,
    input  logic [1:0][ADDRESS_WIDTH-1:0] req_addr,
    input  logic [1:0][DATA_WIDTH-1:0]    req_wdata,
    output logic [1:0]                    resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_rdata,
    output logic                          mem_we,
    output logic [ADDRESS_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t                   state;
    logic                     last_grant;
    logic                     rmw_port;
    logic [ADDRESS_WIDTH-1:0] rmw_addr;
    logic [DATA_WIDTH-1:0]    merge_q;

    logic                     accept;
    logic                     grant_idx;
    logic                     sel_we;
    logic                     sel_sub;
    logic [1:0]               sel_size;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [ADDRESS_WIDTH-1:0] word_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;
    logic [DATA_WIDTH-1:0]    merged;

    // Round-robin grant: only in IDLE; on contention the port not served last wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        accept    = 1'b0;
        grant_idx = 1'b0;
        if (state == IDLE) begin
            if (req_valid == 2'b11) begin
                accept    = 1'b1;
                grant_idx = ~last_grant;
            end else if (req_valid[1]) begin
                accept    = 1'b1;
                grant_idx = 1'b1;
            end else if (req_valid[0]) begin
                accept    = 1'b1;
                grant_idx = 1'b0;
            end
        end
    end

    assign req_ready = accept ? (2'b01 << grant_idx) : 2'b00;

    assign sel_we    = req_we[grant_idx];
    assign sel_size  = req_size[grant_idx];
    assign sel_addr  = req_addr[grant_idx];
    assign sel_wdata = req_wdata[grant_idx];
    assign sel_sub   = ~sel_size[1];
    assign word_addr = {sel_addr[ADDRESS_WIDTH-1:2], 2'b00};

    // Replace the addressed byte or halfword lane(s) of the current memory word.
    always_comb begin
        merged = mem_rdata;
        if (sel_size[0]) begin
            merged[{sel_addr[1], 4'b0000} +: 16] = sel_wdata[15:0];
        end else begin
            merged[{sel_addr[1:0], 3'b000} +: 8] = sel_wdata[7:0];
        end
    end

    // Memory port drive: RMW write-back, accepted transfer, or all-zero when idle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == RMW_WR) begin
            mem_we    = 1'b1;
            mem_addr  = rmw_addr;
            mem_wdata = merge_q;
        end else if (accept) begin
            if (!sel_we) begin
                mem_addr = sel_addr;
            end else if (!sel_sub) begin
                mem_we    = 1'b1;
                mem_addr  = word_addr;
                mem_wdata = sel_wdata;
            end else begin
                mem_addr = word_addr;
            end
        end
    end

    // Sequencer FSM with registered responses and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            resp_valid <= 2'b00;
            resp_rdata <= '0;
            rmw_port   <= 1'b0;
            rmw_addr   <= '0;
            merge_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            resp_valid <= 2'b00;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= grant_idx;
                        if (!sel_we) begin
                            resp_valid[grant_idx] <= 1'b1;
                            resp_rdata            <= mem_rdata;
                        end else if (!sel_sub) begin
                            resp_valid[grant_idx] <= 1'b1;
                            resp_rdata            <= '0;
                        end else begin
                            merge_q  <= merged;
                            rmw_port <= grant_idx;
                            rmw_addr <= word_addr;
                            state    <= RMW_WR;
                        end
                    end
                end
                RMW_WR: begin
                    resp_valid[rmw_port] <= 1'b1;
                    resp_rdata           <= '0;
                    state                <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
